// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared definitions for the Conv2d activation path: fixed-point
//               defaults, tensor geometry defaults, flat-index helper and the
//               packer state encoding. Also used by the result unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  // Fixed-point element format (signed Qm.Q)
  localparam int CNN_N = 16;
  localparam int CNN_Q = 8;

  // Default tensor geometry
  localparam int CNN_H = 3;
  localparam int CNN_W = 4;
  localparam int CNN_C = 2;

  // Packer state encoding
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_t;

  // Channel-major, row-major flat element index
  function automatic int idx(input int ch, input int row, input int col);
    return ch * CNN_H * CNN_W + row * CNN_W + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tensor_packer.sv
`default_nettype none
// ============================================================================
// Module      : tensor_packer
// Description : Collects one signed fixed-point element per valid/ready
//               handshake and assembles a flattened N*H*W*C tensor word that
//               is then held under a valid/ack handshake.
// Ports       : clk, global_rst      - clock, async active-high reset
//               in_data/in_valid/in_last/in_ready - element input stream
//               out_data/out_valid/out_ack        - completed tensor output
//               clear                - synchronous abort of current frame
//               err_len              - one-cycle frame-length mismatch pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_packer
  import cnn_pkg::*;
#(
  parameter int N = CNN_N,
  parameter int Q = CNN_Q,
  parameter int H = CNN_H,
  parameter int W = CNN_W,
  parameter int C = CNN_C
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [N*H*W*C-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ack,
  input  logic             clear,
  output logic             err_len
);

  localparam int E  = H * W * C;
  localparam int CW = $clog2(E + 1);
  localparam logic [CW-1:0] C_LAST = CW'(E - 1);

  // Fractional width only describes the data format; it must fit the element.
  if (Q >= N) begin : g_q_range_check
    $error("tensor_packer: Q must be smaller than N");
  end

  packer_state_t   r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_err_len, w_err_nxt;
  logic            w_take;   // accepted element that is not overridden by clear
  logic            w_done;   // accepted element closes the frame

  assign w_take = in_valid & in_ready & ~clear;
  assign w_done = (r_cnt == C_LAST) | in_last;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err_len <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    in_ready    = (r_state == FILL);
    out_valid   = (r_state == FULL);
    if (clear) begin
      w_state_nxt = FILL;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_take) begin
            if (w_done) begin
              w_state_nxt = FULL;
              w_cnt_nxt   = '0;
              // Mismatch when in_last and the element count disagree
              w_err_nxt   = (r_cnt == C_LAST) ^ in_last;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ack) w_state_nxt = FILL;
        end
        default: w_state_nxt = FILL;
      endcase
    end
  end

  assign err_len = r_err_len;

  // --------------------------------------------------------------------------
  // Slot registers: one decoded write enable per element. A short frame
  // zeroes every slot above the final index in the same cycle.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < E; i++) begin : g_slot
    logic [N-1:0] r_slot;
    logic         w_wr;
    logic         w_zero;

    assign w_wr   = w_take & (r_cnt == CW'(i));
    assign w_zero = w_take & in_last & (r_cnt < CW'(i));

    always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
        r_slot <= '0;
      end else if (w_wr) begin
        r_slot <= in_data;
      end else if (w_zero) begin
        r_slot <= '0;
      end
    end

    assign out_data[i*N +: N] = r_slot;
  end

endmodule
`default_nettype wire
